mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be ADDR_W (default 32, byte address width) and DATA_W (default 32, data width; DATA_W/8 byte enables).
REQ-002 clk  input  1  processor clock (clk_divided domain).
REQ-003 reset_internal  input  1  asynchronous, active-high reset.
REQ-004 cpu_req / cpu_we  input  1 / 1  CPU access request / write select.
REQ-005 cpu_addr / cpu_wdata / cpu_be  input  ADDR_W / DATA_W / DATA_W/8  CPU address, write data, byte enables.
REQ-006 cpu_gnt / cpu_rvalid  output  1 / 1  CPU access issued this cycle / CPU read data valid.
REQ-007 ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_be, ldr_gnt, ldr_rvalid  same widths and directions as the cpu_* ports, for the program loader.
REQ-008 ldr_lock  input  1  loader holds the memory across consecutive accesses while high.
REQ-009 rdata  output  DATA_W  read data, shared by both requesters and qualified by *_rvalid.
REQ-010 mem_en, mem_we, mem_addr, mem_wdata, mem_be  output  1/1/ADDR_W/DATA_W/DATA_W/8  single-port memory command.
REQ-011 mem_rdata  input  DATA_W  memory read data, valid one cycle after a read command.

Function
REQ-012 Handshake: a requester SHALL hold *_req and its command stable until *_gnt=1; a transfer occurs in the cycle where req and gnt are both 1.
REQ-013 gnt SHALL be combinational from req and the arbiter state, and at most one of cpu_gnt and ldr_gnt SHALL be 1 in any cycle.
REQ-014 In a cycle with a grant, mem_en SHALL be 1 and mem_* SHALL equal the granted requester's command; otherwise mem_en=0 and mem_we=0.
REQ-015 Read latency: a granted read in cycle N SHALL produce rdata=mem_rdata and the matching *_rvalid=1 in cycle N+1 only. Writes produce no rvalid.
REQ-016 Back-to-back grants SHALL be allowed with a throughput of one access per cycle and no bubble.
REQ-017 The FSM SHALL have states IDLE, CPU_OWN and LDR_OWN, where the state is the last owner; IDLE is entered only from reset.
REQ-018 Lock: when the loader is granted with ldr_lock=1, the FSM SHALL enter LDR_LOCKED, in which only the loader is granted. It SHALL return to LDR_OWN on the first cycle where ldr_lock=0.
REQ-019 While in LDR_LOCKED, cpu_req SHALL be held off indefinitely, with cpu_gnt=0.
REQ-020 Simultaneous requests SHALL be resolved per REQ-026/REQ-027; a single requester SHALL be granted in the same cycle it requests.
REQ-021 A requester that drops req without a grant SHALL be legal; no state change results.
REQ-022 The arbiter SHALL track one outstanding read owner flag so that rvalid is routed to the correct requester even when ownership changes in cycle N+1.

Reset
REQ-023 On reset_internal=1, asynchronously: state=IDLE, both rvalid=0, outstanding-read flag cleared, rdata=0, and lock cleared. All gnt and mem_en outputs SHALL be 0 while reset is asserted.
REQ-024 A read granted in the cycle before reset SHALL produce no rvalid after reset.
REQ-025 The first request after reset release SHALL be grantable in the first cycle.

Configuration
REQ-026 With ARB_ROUND_ROBIN_EN defined: on a simultaneous request, the requester that is not the last owner SHALL win; from IDLE, the CPU wins.
REQ-027 Without ARB_ROUND_ROBIN_EN: fixed priority SHALL apply, with the loader always winning over the CPU.

Structure
REQ-028 The package mem_arb_pkg SHALL hold the FSM state enum (IDLE, CPU_OWN, LDR_OWN, LDR_LOCKED) and the owner encoding constants OWN_CPU and OWN_LDR.
REQ-029 There SHALL be one sub-module, arb_pick: a combinational two-way picker with inputs for the requests and the last owner, and outputs for the one-hot grant.

Verification
REQ-030 CPU read of 0x10 with mem_rdata=0xDEADBEEF: cpu_gnt in cycle N; cpu_rvalid=1 and rdata=0xDEADBEEF in cycle N+1.
REQ-031 Both requesting continuously from IDLE: with RR, grants CPU,LDR,CPU,LDR; without RR, LDR every cycle.
REQ-032 Loader with ldr_lock=1 writing 4 words to 0x0..0xC while cpu_req=1: the 4 writes are issued consecutively, cpu_gnt=0 throughout, and cpu_gnt=1 in the cycle after ldr_lock falls.
REQ-033 Loader read granted in cycle N and CPU granted in cycle N+1: ldr_rvalid=1 in N+1, cpu_rvalid=0 in N+1.
REQ-034 Reset asserted in the cycle after a read grant: no rvalid, and all outputs 0. After release, a new cpu_req is granted in the first cycle.
REQ-035 Write with cpu_be=4'b0011: mem_be=4'b0011 and mem_we=1 in the grant cycle, and no rvalid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the memory arbiter.
// Holds the arbiter FSM state enum and the owner encoding used by the picker.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CPU_OWN,
      LDR_OWN,
      LDR_LOCKED
   } arb_state_e;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_LDR = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational two-way picker, one-hot grant out.
// Ports: cpu_req_i, ldr_req_i, last_own_i in; cpu_gnt_o, ldr_gnt_o out.
// ARB_ROUND_ROBIN_EN: non-last owner wins a tie; else loader always wins.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic cpu_req_i,
   input  logic ldr_req_i,
   input  logic last_own_i,
   output logic cpu_gnt_o,
   output logic ldr_gnt_o
);

   logic cpu_wins;

`ifdef ARB_ROUND_ROBIN_EN
   assign cpu_wins = cpu_req_i &
                     (~ldr_req_i | (last_own_i == OWN_LDR));
`else
   logic unused_own;
   assign unused_own = last_own_i;
   assign cpu_wins   = cpu_req_i & ~ldr_req_i;
`endif

   assign cpu_gnt_o = cpu_wins;
   assign ldr_gnt_o = ldr_req_i & ~cpu_wins;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: CPU / program-loader arbiter for a single-port memory.
// Ports: cpu_* and ldr_* request/grant/rvalid, ldr_lock, rdata, mem_* cmd.
// ARB_ROUND_ROBIN_EN selects round-robin tie-break (see arb_pick).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset_internal,
   input  logic                cpu_req,
   input  logic                cpu_we,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [DATA_W-1:0]   cpu_wdata,
   input  logic [DATA_W/8-1:0] cpu_be,
   output logic                cpu_gnt,
   output logic                cpu_rvalid,
   input  logic                ldr_req,
   input  logic                ldr_we,
   input  logic [ADDR_W-1:0]   ldr_addr,
   input  logic [DATA_W-1:0]   ldr_wdata,
   input  logic [DATA_W/8-1:0] ldr_be,
   output logic                ldr_gnt,
   output logic                ldr_rvalid,
   input  logic                ldr_lock,
   output logic [DATA_W-1:0]   rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata
);

   arb_state_e state_q, state_d;
   logic       rd_pend_q, rd_pend_d;
   logic       rd_own_q, rd_own_d;
   logic       locked, last_own;
   logic       pick_cpu, pick_ldr;

   assign locked   = (state_q == LDR_LOCKED);
   // IDLE counts as "loader last" so the CPU wins the first tie.
   assign last_own = (state_q == CPU_OWN) ? OWN_CPU : OWN_LDR;

   arb_pick u_pick (
      .cpu_req_i  (cpu_req & ~locked & ~reset_internal),
      .ldr_req_i  (ldr_req & ~reset_internal),
      .last_own_i (last_own),
      .cpu_gnt_o  (pick_cpu),
      .ldr_gnt_o  (pick_ldr)
   );

   assign cpu_gnt = pick_cpu;
   assign ldr_gnt = pick_ldr;

   always_comb begin
      mem_en    = pick_cpu | pick_ldr;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      unique case (1'b1)
         pick_cpu: begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_be    = cpu_be;
         end
         pick_ldr: begin
            mem_we    = ldr_we;
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
            mem_be    = ldr_be;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      if (pick_ldr)
         state_d = ldr_lock ? LDR_LOCKED : LDR_OWN;
      else if (pick_cpu)
         state_d = CPU_OWN;
      else if (locked && !ldr_lock)
         state_d = LDR_OWN;
      rd_pend_d = mem_en & ~mem_we;
      rd_own_d  = pick_ldr ? OWN_LDR : OWN_CPU;
   end

   always_ff @(posedge clk or posedge reset_internal) begin
      if (reset_internal) begin
         state_q   <= IDLE;
         rd_pend_q <= 1'b0;
         rd_own_q  <= OWN_CPU;
      end else begin
         state_q   <= state_d;
         rd_pend_q <= rd_pend_d;
         rd_own_q  <= rd_own_d;
      end
   end

   // Read data comes straight from memory one cycle after the command;
   // the owner flag steers rvalid even if the grant has since moved.
   assign cpu_rvalid = rd_pend_q & (rd_own_q == OWN_CPU);
   assign ldr_rvalid = rd_pend_q & (rd_own_q == OWN_LDR);
   assign rdata      = rd_pend_q ? mem_rdata : '0;

endmodule
